// File: rtl/door_plant.sv
// ---------------------------------------------------------------------------
// door_plant
//
// Purpose:
//   Synthesizable behavioural model of a garage door. It sits on the far side
//   of a door controller's motor interface. It turns motor_up / motor_dn drive
//   into a stepped position and into up/down limit switch signals. It also
//   flags illegal drive as a latched fault:
//     - both motors on at once, or
//     - driving into an active limit for OVERRUN consecutive cycles.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous, active-high reset
//   motor_up    in   raise command
//   motor_dn    in   lower command
//   clr_fault   in   single-cycle pulse, leaves the fault state
//   obstruct    in   (DOOR_OBSTRUCT_EN only) obstacle under the closing door
//   obstructed  out  (DOOR_OBSTRUCT_EN only) closing was inhibited last cycle
//   up_limit    out  door fully up   (position == TRAVEL)
//   dn_limit    out  door fully down (position == 0)
//   position    out  current door position, 0..TRAVEL
//   moving      out  door is opening or closing
//   fault       out  door is in the fault state
//
// Optional feature macro: DOOR_OBSTRUCT_EN
//   Adds the obstruct input and the obstructed output. While closing with
//   obstruct high, travel stalls and the overrun counter runs.
// ---------------------------------------------------------------------------
module door_plant #(
    parameter int TRAVEL   = 8,
    parameter int POS_W    = 4,
    parameter int PRESCALE = 2,
    parameter int OVERRUN  = 4,
    parameter int INIT_UP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             motor_up,
    input  logic             motor_dn,
    input  logic             clr_fault,
`ifdef DOOR_OBSTRUCT_EN
    input  logic             obstruct,
    output logic             obstructed,
`endif
    output logic             up_limit,
    output logic             dn_limit,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             fault
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int OVR_W = $clog2(OVERRUN + 1);

    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] POS_BOT   = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_INIT  = (INIT_UP != 0) ? POS_TOP : POS_BOT;
    localparam logic             INIT_UP_B = (INIT_UP != 0);
    localparam logic [PRE_W-1:0] PRE_ZERO  = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [OVR_W-1:0] OVR_ZERO  = {OVR_W{1'b0}};
    localparam logic [OVR_W-1:0] OVR_LIMIT = OVR_W'(OVERRUN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_CLOSING = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [POS_W-1:0]   pos_r;
    logic [POS_W-1:0]   pos_s;
    logic [PRE_W-1:0]   pre_r;
    logic [PRE_W-1:0]   pre_s;
    logic [OVR_W-1:0]   ovr_r;
    logic [OVR_W-1:0]   ovr_s;
    logic [OVR_W-1:0]   ovr_inc_s;
    logic               up_limit_r;
    logic               dn_limit_r;
    logic               moving_r;
    logic               fault_r;
    logic               both_s;
    logic               at_top_s;
    logic               at_bot_s;
    logic               obstruct_s;

    assign both_s    = motor_up & motor_dn;
    assign at_top_s  = (pos_r == POS_TOP);
    assign at_bot_s  = (pos_r == POS_BOT);
    assign ovr_inc_s = ovr_r + OVR_W'(1);

`ifdef DOOR_OBSTRUCT_EN
    assign obstruct_s = obstruct;
`else
    assign obstruct_s = 1'b0;
`endif

    // Next-state, next-position and counter logic for the door FSM
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        pre_s   = pre_r;
        ovr_s   = ovr_r;
        case (state_r)
            ST_IDLE: begin
                // Counters are already clear in IDLE; keep them that way on entry to motion.
                pre_s = PRE_ZERO;
                ovr_s = OVR_ZERO;
                if (both_s) begin
                    state_s = ST_FAULT;
                end else if (motor_up) begin
                    state_s = ST_OPENING;
                end else if (motor_dn) begin
                    state_s = ST_CLOSING;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OPENING: begin
                if (both_s) begin
                    state_s = ST_FAULT;
                end else if (motor_up) begin
                    if (at_top_s) begin
                        // Pushing against the top stop: prescaler frozen, overrun runs.
                        ovr_s = ovr_inc_s;
                        if (ovr_inc_s == OVR_LIMIT) begin
                            state_s = ST_FAULT;
                        end else begin
                            state_s = ST_OPENING;
                        end
                    end else begin
                        ovr_s = OVR_ZERO;
                        if (pre_r == PRE_LAST) begin
                            pos_s = pos_r + POS_W'(1);
                            pre_s = PRE_ZERO;
                        end else begin
                            pre_s = pre_r + PRE_W'(1);
                        end
                    end
                end else if (motor_dn) begin
                    state_s = ST_CLOSING;
                    pre_s   = PRE_ZERO;
                    ovr_s   = OVR_ZERO;
                end else begin
                    state_s = ST_IDLE;
                    pre_s   = PRE_ZERO;
                    ovr_s   = OVR_ZERO;
                end
            end
            ST_CLOSING: begin
                if (both_s) begin
                    state_s = ST_FAULT;
                end else if (motor_dn) begin
                    if (at_bot_s || obstruct_s) begin
                        // Bottom stop or obstacle: no step, prescaler frozen, overrun runs.
                        ovr_s = ovr_inc_s;
                        if (ovr_inc_s == OVR_LIMIT) begin
                            state_s = ST_FAULT;
                        end else begin
                            state_s = ST_CLOSING;
                        end
                    end else begin
                        ovr_s = OVR_ZERO;
                        if (pre_r == PRE_LAST) begin
                            pos_s = pos_r - POS_W'(1);
                            pre_s = PRE_ZERO;
                        end else begin
                            pre_s = pre_r + PRE_W'(1);
                        end
                    end
                end else if (motor_up) begin
                    state_s = ST_OPENING;
                    pre_s   = PRE_ZERO;
                    ovr_s   = OVR_ZERO;
                end else begin
                    state_s = ST_IDLE;
                    pre_s   = PRE_ZERO;
                    ovr_s   = OVR_ZERO;
                end
            end
            ST_FAULT: begin
                // Position frozen and motors ignored until the fault is cleared.
                if (clr_fault) begin
                    state_s = ST_IDLE;
                    pre_s   = PRE_ZERO;
                    ovr_s   = OVR_ZERO;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s = ST_FAULT;
            end
        endcase
    end

    // State, counters and registered outputs; limits follow the next position
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pos_r      <= POS_INIT;
            pre_r      <= PRE_ZERO;
            ovr_r      <= OVR_ZERO;
            up_limit_r <= INIT_UP_B;
            dn_limit_r <= ~INIT_UP_B;
            moving_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pos_r      <= pos_s;
            pre_r      <= pre_s;
            ovr_r      <= ovr_s;
            up_limit_r <= (pos_s == POS_TOP);
            dn_limit_r <= (pos_s == POS_BOT);
            moving_r   <= (state_s == ST_OPENING) || (state_s == ST_CLOSING);
            fault_r    <= (state_s == ST_FAULT);
        end
    end

`ifdef DOOR_OBSTRUCT_EN
    logic obstructed_r;

    // Flag a cycle in which closing travel was held back by the obstacle input
    always_ff @(posedge clk) begin
        if (rst) begin
            obstructed_r <= 1'b0;
        end else begin
            obstructed_r <= (state_r == ST_CLOSING) & motor_dn & ~motor_up & obstruct;
        end
    end

    assign obstructed = obstructed_r;
`endif

    assign position = pos_r;
    assign up_limit = up_limit_r;
    assign dn_limit = dn_limit_r;
    assign moving   = moving_r;
    assign fault    = fault_r;

endmodule
